pulse_rst_loop_fhsl: RTL and testbench
======================================

Name: pulse_rst_loop_fhsl

Overview:
Periodic pulse generator restarted by reset. After reset is released it waits a programmable first delay, then emits a repeating pulse train with programmable high time and total period. All timing is given in ns and converted to clock cycles at elaboration. Used as a timer/tick source in standard-module designs.

Parameters:
CLK_PERIOD_TIME, 20, clock period in ns (integer, >0)
FIRST_DELAY_TIME, 20, delay in ns from reset release to the first pulse rising edge
HIGH_TIME, 20, pulse high duration in ns
TOTAL_TIME, 40, pulse period in ns (high plus low)

Ports:
CLK_I  input  1  system clock, all logic on rising edge
RST_I  input  1  reset, synchronous, active-high
PULSE_O  output  1  registered pulse output

Behaviour:
- Interface: one clock CLK_I; RST_I is synchronous and active-high.
- Derived constants use integer division with truncation: FIRST_CYC = FIRST_DELAY_TIME/CLK_PERIOD_TIME, HIGH_CYC = HIGH_TIME/CLK_PERIOD_TIME, TOTAL_CYC = TOTAL_TIME/CLK_PERIOD_TIME. If TOTAL_CYC is 0, it is forced to 1. Counter width is 32 bits.
- Reset: while RST_I is sampled high, PULSE_O is 0, the state is DELAY, and the counter is 0.
- Edge numbering: n = 1 is the first rising edge with RST_I sampled low.
- DELAY state: PULSE_O stays 0 on edges 1..FIRST_CYC.
  - On edge FIRST_CYC+1, PULSE_O is set to 1, the state goes to HIGH, and the counter is 1.
  - If HIGH_CYC is 0, the state goes straight to LOW with PULSE_O 0.
- HIGH state: PULSE_O stays 1 for exactly HIGH_CYC clock cycles. It then goes to LOW with PULSE_O 0.
- LOW state: PULSE_O stays 0 for exactly TOTAL_CYC−HIGH_CYC cycles. It then goes to HIGH with PULSE_O 1.
- The period is exactly TOTAL_CYC cycles and repeats indefinitely.
- If HIGH_CYC >= TOTAL_CYC, PULSE_O stays 1 permanently after the delay (LOW is never entered).
- If FIRST_CYC is 0, the first pulse starts on edge 1.
- Reset asserted mid-operation: on the next sampled edge PULSE_O goes to 0 and the sequence restarts from DELAY after release. No partial pulse is preserved.
- PULSE_O is driven directly from a flop, with no combinational path from RST_I.

Test Plan:
- Defaults (20 ns clock, edges at 10, 30, 50… ns), RST_I=1 until 55 ns:
  - PULSE_O=0 through 90 ns.
  - 1 from the 90 ns edge, 0 from 110 ns, 1 from 130 ns: a 40 ns period with 20 ns high, continuing.
- FIRST_DELAY_TIME=100, HIGH_TIME=40, TOTAL_TIME=100 -> after release:
  - 5 low cycles, then a repeating pattern of 2 high and 3 low.
  - Count at least 4 periods.
- FIRST_DELAY_TIME=0 -> PULSE_O=1 on edge 1 after release.
- HIGH_TIME=0 -> PULSE_O constantly 0. HIGH_TIME=TOTAL_TIME -> PULSE_O constantly 1 after the delay.
- Assert RST_I for 1 cycle while PULSE_O is high -> PULSE_O=0 on the next edge. After release the delay is re-applied in full before the next pulse.
- Non-integer ratio (CLK_PERIOD_TIME=20, HIGH_TIME=30, TOTAL_TIME=70) -> 1 high cycle, 2 low cycles (truncated values).

Source files
------------

// File: rtl/pulse_rst_loop_fhsl.sv
// Periodic pulse generator restarted by synchronous reset: a programmable first
// delay, then a pulse train with programmable high time and period.
module pulse_rst_loop_fhsl #(
  parameter int CLK_PERIOD_TIME  = 20,
  parameter int FIRST_DELAY_TIME = 20,
  parameter int HIGH_TIME        = 20,
  parameter int TOTAL_TIME       = 40
) (
  input  logic CLK_I,
  input  logic RST_I,
  output logic PULSE_O
);

  localparam logic [31:0] FIRST_CYC = 32'(FIRST_DELAY_TIME / CLK_PERIOD_TIME);
  localparam logic [31:0] HIGH_CYC  = 32'(HIGH_TIME / CLK_PERIOD_TIME);
  localparam logic [31:0] TOTAL_RAW = 32'(TOTAL_TIME / CLK_PERIOD_TIME);
  localparam logic [31:0] TOTAL_CYC = (TOTAL_RAW == 32'd0) ? 32'd1 : TOTAL_RAW;
  localparam logic [31:0] LOW_CYC   = (TOTAL_CYC > HIGH_CYC) ? (TOTAL_CYC - HIGH_CYC) : 32'd0;

  localparam logic [1:0] ST_DELAY = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    case (state_q)
      ST_DELAY: begin
        // cnt_q counts released edges already seen, so the first pulse lands on edge FIRST_CYC+1.
        if (cnt_q == FIRST_CYC) begin
          cnt_d = 32'd1;
          if (HIGH_CYC == 32'd0) begin
            state_d = ST_LOW;
            pulse_d = 1'b0;
          end else begin
            state_d = ST_HIGH;
            pulse_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_HIGH: begin
        if (HIGH_CYC >= TOTAL_CYC) begin
          pulse_d = 1'b1;
        end else if (cnt_q >= HIGH_CYC) begin
          state_d = ST_LOW;
          pulse_d = 1'b0;
          cnt_d   = 32'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_LOW: begin
        if (HIGH_CYC == 32'd0) begin
          pulse_d = 1'b0;
        end else if (cnt_q >= LOW_CYC) begin
          state_d = ST_HIGH;
          pulse_d = 1'b1;
          cnt_d   = 32'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_DELAY;
        cnt_d   = 32'd0;
        pulse_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_DELAY;
      cnt_q   <= 32'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign PULSE_O = pulse_q;

endmodule

// File: tb/tb_pulse_rst_loop_fhsl.sv
// Directed bench: six parameterisations share clock and reset; each row of the
// vector table is one rising edge with the expected pulse of every instance.
module tb_pulse_rst_loop_fhsl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] p;

  always #10 clk = ~clk;

  // bit0 defaults, bit1 delay100/high40/total100, bit2 first delay 0,
  // bit3 high 0, bit4 high == total, bit5 high30/total70 (truncated ratio)
  pulse_rst_loop_fhsl u_def (.CLK_I(clk), .RST_I(rst), .PULSE_O(p[0]));
  pulse_rst_loop_fhsl #(.FIRST_DELAY_TIME(100), .HIGH_TIME(40), .TOTAL_TIME(100))
    u_a (.CLK_I(clk), .RST_I(rst), .PULSE_O(p[1]));
  pulse_rst_loop_fhsl #(.FIRST_DELAY_TIME(0))
    u_z (.CLK_I(clk), .RST_I(rst), .PULSE_O(p[2]));
  pulse_rst_loop_fhsl #(.HIGH_TIME(0))
    u_h0 (.CLK_I(clk), .RST_I(rst), .PULSE_O(p[3]));
  pulse_rst_loop_fhsl #(.HIGH_TIME(40), .TOTAL_TIME(40))
    u_ht (.CLK_I(clk), .RST_I(rst), .PULSE_O(p[4]));
  pulse_rst_loop_fhsl #(.HIGH_TIME(30), .TOTAL_TIME(70))
    u_n (.CLK_I(clk), .RST_I(rst), .PULSE_O(p[5]));

  typedef struct {
    logic       rst;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [5:0] e);
    vec_t v;
    v.rst = r;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  initial begin
    // held in reset
    add(1'b1, 6'b000000);
    add(1'b1, 6'b000000);
    add(1'b1, 6'b000000);
    // released edges n = 1..26
    add(1'b0, 6'b000100); // 1
    add(1'b0, 6'b110001); // 2
    add(1'b0, 6'b010100); // 3
    add(1'b0, 6'b010001); // 4
    add(1'b0, 6'b110100); // 5
    add(1'b0, 6'b010011); // 6
    add(1'b0, 6'b010110); // 7
    add(1'b0, 6'b110001); // 8
    add(1'b0, 6'b010100); // 9
    add(1'b0, 6'b010001); // 10
    add(1'b0, 6'b110110); // 11
    add(1'b0, 6'b010011); // 12
    add(1'b0, 6'b010100); // 13
    add(1'b0, 6'b110001); // 14
    add(1'b0, 6'b010100); // 15
    add(1'b0, 6'b010011); // 16
    add(1'b0, 6'b110110); // 17
    add(1'b0, 6'b010001); // 18
    add(1'b0, 6'b010100); // 19
    add(1'b0, 6'b110001); // 20
    add(1'b0, 6'b010110); // 21
    add(1'b0, 6'b010011); // 22
    add(1'b0, 6'b110100); // 23
    add(1'b0, 6'b010001); // 24
    add(1'b0, 6'b010100); // 25
    add(1'b0, 6'b110011); // 26
    // one-cycle reset while the default pulse is high
    add(1'b1, 6'b000000);
    // full restart from the delay
    add(1'b0, 6'b000100); // 1
    add(1'b0, 6'b110001); // 2
    add(1'b0, 6'b010100); // 3
    add(1'b0, 6'b010001); // 4
    add(1'b0, 6'b110100); // 5
    add(1'b0, 6'b010011); // 6
    add(1'b0, 6'b010110); // 7

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), p, vecs[i].exp);
    end

    // Reset while the long-delay instance is high, then time its re-applied delay.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", p, 6'b000000);
    rst = 1'b0;
    begin
      int edge_n;
      edge_n = 0;
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk);
        #1;
        if (p[1] === 1'b1) begin
          edge_n = n;
          break;
        end
      end
      checks++;
      if (edge_n != 6) begin
        errors++;
        $display("FAIL a_first_pulse_edge: got %0d expected 6", edge_n);
      end
      // two high cycles then three low before the next rise
      @(posedge clk);
      #1;
      check("a_high2", {5'b0, p[1]}, 6'b000001);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        check($sformatf("a_low%0d", k), {5'b0, p[1]}, 6'b000000);
      end
      @(posedge clk);
      #1;
      check("a_rise_again", {5'b0, p[1]}, 6'b000001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
